// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic conflict monitor: light codes from the
// controller, latched fault causes, monitor states and lamp drive patterns.
package traffic_pkg;

    // Light codes produced by the upstream controller; everything else is illegal.
    localparam logic [2:0] LIGHT_GREEN  = 3'd1;
    localparam logic [2:0] LIGHT_YELLOW = 3'd2;
    localparam logic [2:0] LIGHT_RED    = 3'd3;

    // Fault causes; the numeric order doubles as the priority order (lowest wins).
    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_CONFLICT = 3'd1,
        FLT_ILLEGAL  = 3'd2,
        FLT_NOYEL    = 3'd3,
        FLT_SHORTYEL = 3'd4
    } fault_e;

    typedef enum logic [1:0] {
        MON_STARTUP = 2'd0,
        MON_RUN     = 2'd1,
        MON_FAULT   = 2'd2
    } mon_state_e;

    // Lamp enables are {red, yellow, green}.
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Map a legal light code onto its lamp pattern; illegal codes light nothing.
    function automatic logic [2:0] lamp_decode(input logic [2:0] light);
        case (light)
            LIGHT_GREEN:  return LAMP_G;
            LIGHT_YELLOW: return LAMP_Y;
            LIGHT_RED:    return LAMP_R;
            default:      return LAMP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/traffic_dir_tracker.sv
// Per-direction tracker: remembers the previous sample and the length of the
// current yellow run, and flags the per-direction rule violations on the
// current sample. Flags are raw; the top decides whether they count.
module traffic_dir_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sample,
    output logic       is_green,
    output logic       illegal,
    output logic       no_yellow,
    output logic       short_yellow
);

    localparam logic [7:0] MIN_Y = 8'(MIN_YELLOW);

    logic [2:0] history;
    logic [7:0] yel_cnt;

    // History follows the sample one cycle behind; the yellow run length saturates.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            history <= LIGHT_RED;
            yel_cnt <= 8'd0;
        end else begin
            history <= sample;
            if (sample == LIGHT_YELLOW) begin
                if (yel_cnt != 8'hFF) yel_cnt <= yel_cnt + 8'd1;
            end else begin
                yel_cnt <= 8'd0;
            end
        end
    end

    assign is_green     = (sample == LIGHT_GREEN);
    assign illegal      = !((sample == LIGHT_GREEN) || (sample == LIGHT_YELLOW) ||
                            (sample == LIGHT_RED));
    assign no_yellow    = (history == LIGHT_GREEN) && (sample == LIGHT_RED);
    // yel_cnt holds the full yellow run by the time the sample turns red.
    assign short_yellow = (history == LIGHT_YELLOW) && (sample == LIGHT_RED) &&
                          (yel_cnt < MIN_Y);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the 4-way light controller and the lamp drivers.
// Stage 1 registers the light codes; stage 2 checks them and registers the
// lamps from the next state, so an offending pattern never reaches a lamp.
// Any violation latches a fault and flashes all-way red until cleared.
// Optional build macro MON_FAULT_CNT_EN adds a saturating fault_count output.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW  = 5,
    parameter int FLASH_HALF  = 8,
    parameter int STARTUP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] east_in,
    input  logic [2:0] south_in,
    input  logic [2:0] west_in,
    input  logic [2:0] north_in,
    input  logic       clear,
    output logic [2:0] lamp_e,
    output logic [2:0] lamp_s,
    output logic [2:0] lamp_w,
    output logic [2:0] lamp_n,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef MON_FAULT_CNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYC - 1);
    localparam logic [15:0] FLASH_LAST   = 16'(FLASH_HALF - 1);

    // Direction index: 0=east, 1=south, 2=west, 3=north.
    logic [3:0][2:0] sample;
    logic [3:0][2:0] lamp_q, lamp_next;
    logic [3:0]      is_green, illegal, no_yellow, short_yellow;
    logic            conflict;
    fault_e          violation;

    mon_state_e state, state_next;
    fault_e     code_q, code_next;
    logic [15:0] startup_cnt, startup_next;
    logic [15:0] flash_cnt, flash_cnt_next;
    logic        flash_phase, phase_next;

    // Stage 1: capture the controller outputs every cycle.
    always_ff @(posedge clk) begin
        if (rst) sample <= {4{LIGHT_RED}};
        else     sample <= {north_in, west_in, south_in, east_in};
    end

    for (genvar d = 0; d < 4; d++) begin : g_dir
        traffic_dir_tracker #(.MIN_YELLOW(MIN_YELLOW)) u_tracker (
            .clk          (clk),
            .rst          (rst),
            .sample       (sample[d]),
            .is_green     (is_green[d]),
            .illegal      (illegal[d]),
            .no_yellow    (no_yellow[d]),
            .short_yellow (short_yellow[d])
        );
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign conflict = (is_green & (is_green - 4'd1)) != 4'd0;

    // Priority encoder: the lowest-numbered cause wins.
    always_comb begin
        violation = FLT_NONE;
        if (conflict)           violation = FLT_CONFLICT;
        else if (|illegal)      violation = FLT_ILLEGAL;
        else if (|no_yellow)    violation = FLT_NOYEL;
        else if (|short_yellow) violation = FLT_SHORTYEL;
    end

    // Next-state, counter and lamp logic for the monitor FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next     = state;
        code_next      = code_q;
        startup_next   = startup_cnt;
        flash_cnt_next = flash_cnt;
        phase_next     = flash_phase;
        lamp_next      = {4{LAMP_R}};

        case (state)
            MON_STARTUP: begin
                if (startup_cnt == STARTUP_LAST) state_next = MON_RUN;
                else                             startup_next = startup_cnt + 16'd1;
            end
            MON_RUN: begin
                if (violation != FLT_NONE) begin
                    state_next     = MON_FAULT;
                    code_next      = violation;
                    phase_next     = 1'b1;
                    flash_cnt_next = 16'd0;
                end
            end
            MON_FAULT: begin
                if (clear) begin
                    state_next   = MON_STARTUP;
                    code_next    = FLT_NONE;
                    startup_next = 16'd0;
                end else if (flash_cnt == FLASH_LAST) begin
                    flash_cnt_next = 16'd0;
                    phase_next     = ~flash_phase;
                end else begin
                    flash_cnt_next = flash_cnt + 16'd1;
                end
            end
            default: begin
                state_next   = MON_STARTUP;
                code_next    = FLT_NONE;
                startup_next = 16'd0;
            end
        endcase

        // Lamps follow the state being entered, not the one being left.
        case (state_next)
            MON_RUN: begin
                for (int d = 0; d < 4; d++) lamp_next[d] = lamp_decode(sample[d]);
            end
            MON_FAULT: lamp_next = {4{phase_next, 2'b00}};
            default:   lamp_next = {4{LAMP_R}};
        endcase
    end

    // Stage 2 registers: FSM state, latched cause, counters and lamp drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MON_STARTUP;
            code_q      <= FLT_NONE;
            startup_cnt <= 16'd0;
            flash_cnt   <= 16'd0;
            flash_phase <= 1'b1;
            lamp_q      <= {4{LAMP_R}};
        end else begin
            state       <= state_next;
            code_q      <= code_next;
            startup_cnt <= startup_next;
            flash_cnt   <= flash_cnt_next;
            flash_phase <= phase_next;
            lamp_q      <= lamp_next;
        end
    end

`ifdef MON_FAULT_CNT_EN
    // Count fault entries; clear leaves the tally alone, only rst zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count <= 8'd0;
        end else if (state == MON_RUN && state_next == MON_FAULT &&
                     fault_count != 8'hFF) begin
            fault_count <= fault_count + 8'd1;
        end
    end
`endif

    assign lamp_e     = lamp_q[0];
    assign lamp_s     = lamp_q[1];
    assign lamp_w     = lamp_q[2];
    assign lamp_n     = lamp_q[3];
    assign fault      = (state == MON_FAULT);
    assign fault_code = code_q;

endmodule
